video_half_scaler: RTL and testbench
====================================

// Module: video_half_scaler
// PURPOSE
//  2:1 horizontal and vertical downscaler for one RGB565 camera/test stream.
//  Sits directly upstream of each Frame_top Img<n> input, so each of the four
//  quadrant channels carries 640x360 from a 1280x720 source.
//  Output uses the same vs/de/data format, with sparse de: one pulse per 2x2 input block.
// PARAMETERS
//  IMG_COL  1280  active pixels per input line; odd value -> last pixel dropped
//  IMG_ROW  720   active lines per input frame; odd value -> last line dropped
//  ADDR_W   10    line-buffer address width; 2**ADDR_W >= IMG_COL/2
// PORTS
//  Img_pclk_i  in   1   pixel clock, sole clock
//  sys_rst_n   in   1   reset, asynchronous, active-low
//  Img_vs      in   1   frame sync; high = vertical blank, low = frame active
//  Img_de      in   1   pixel valid
//  Img_data    in   16  RGB565 {R[15:11],G[10:5],B[4:0]}
//  Img_vs_o    out  1   Img_vs delayed exactly 2 cycles
//  Img_de_o    out  1   scaled-pixel valid, single-cycle pulses
//  Img_data_o  out  16  scaled RGB565
// BEHAVIOUR
//  Reset: Img_vs_o=0, Img_de_o=0, Img_data_o=0; FSM->S_IDLE; col/row counters=0.
//   Line-buffer contents are don't-care.
//  FSM states and transitions:
//   S_IDLE: Img_vs high -> S_IDLE; vs low -> S_EVEN.
//   S_EVEN: de falling edge -> S_ODD.
//   S_ODD:  de falling edge -> S_EVEN.
//   Any state: Img_vs high -> S_IDLE next cycle; counters cleared; pipeline de flushed.
//  col counter:
//   Increments on each de=1 cycle; cleared on de fall.
//   Pixels with col>=IMG_COL are ignored until de falls.
//  row counter:
//   Increments on each de fall; lines with row>=IMG_ROW are ignored.
//  Horizontal pair (col even/odd):
//   Even column: hold the pixel.
//   Odd column: per-channel sums hR=R0+R1 (6b), hG (7b), hB (6b).
//  S_EVEN, odd column: write {hR,hG,hB} (19b) to line RAM at col>>1. No output.
//  S_ODD, odd column, 2x2 box average:
//   Read line RAM at col>>1; the read is issued on the even column.
//   Output = (hX_even + hX_odd + 2) >> 2 per channel. Rounded; max sum 126/254 -> no overflow.
//  Latency: Img_de_o/Img_data_o register 2 cycles after the odd-column/odd-row input pixel.
//   Img_vs_o uses the same 2-cycle delay, so de/vs alignment is preserved.
//  Img_data_o holds its last value when Img_de_o=0.
//  Boundary cases:
//   Unpaired trailing pixel or line -> no output.
//   Short line (de drops early): processed up to the last complete pair.
//   vs rising mid-line: no partial output; pending pipeline de is killed.
//   sys_rst_n asserted mid-frame: immediate clear; resume at the next vs low.
// CONFIGURATION
//  HALF_SCALE_AVG_EN defined (default build): 2x2 rounded box average, as above, with line RAM.
//  HALF_SCALE_AVG_EN undefined: pure decimation; no line RAM instantiated.
//   Output = top-left pixel of each block (even row, even column), emitted in S_EVEN.
//   Same 2-cycle latency, same vs delay.
// STRUCTURE
//  Shared header scaler_defs.vh:
//   RGB565 field slices, sum widths (6/7/6), FSM encodings S_IDLE/S_EVEN/S_ODD, LAT=2.
//  Sub-module half_line_ram:
//   Simple dual-port, 2**ADDR_W x 19 bits, registered read, one write port, one read port.
//   Instantiated only under HALF_SCALE_AVG_EN.
// TESTING
//  1. Flat frame, all pixels 16'hFFFF, 1280x720
//     -> 640x360 pulses, every output 16'hFFFF, Img_vs_o = Img_vs delayed 2 cycles.
//  2. Block {R}=1,2,3,4 (G=B=0), AVG_EN
//     -> R_out=(10+2)>>2=3; block R=0,0,0,1 -> R_out=0.
//  3. Ramp Img_data=col index, no AVG_EN
//     -> outputs 0,2,4,... on even rows only; de pulse 2 cycles after the even pixel.
//  4. IMG_COL=5, IMG_ROW=3 frame
//     -> exactly 2 outputs per frame; col 4 and row 2 dropped.
//  5. Img_vs high after 100 pixels of line 1
//     -> no stray de_o; next frame output count correct.
//  6. sys_rst_n low for 3 cycles mid-line
//     -> all outputs 0 next edge; next frame count = 640x360.

Source files
------------

// File: rtl/video_half_scaler_pkg.sv
// Shared types and helpers for the 2:1 RGB565 downscaler: pixel and half-sum
// layouts, FSM encoding, pipeline latency and the channel arithmetic.
package video_half_scaler_pkg;

  localparam int LAT  = 2;
  localparam int HR_W = 6;
  localparam int HG_W = 7;
  localparam int HB_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVEN = 2'd1,
    S_ODD  = 2'd2
  } state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [HR_W-1:0] r;
    logic [HG_W-1:0] g;
    logic [HB_W-1:0] b;
  } hsum_t;

  localparam int HSUM_W = $bits(hsum_t);

  function automatic hsum_t pair_sum(input rgb565_t a, input rgb565_t b);
    hsum_t s;
    s.r = HR_W'(a.r) + HR_W'(b.r);
    s.g = HG_W'(a.g) + HG_W'(b.g);
    s.b = HB_W'(a.b) + HB_W'(b.b);
    return s;
  endfunction

  // Rounded mean of four pixels given two horizontal pair sums.
  function automatic rgb565_t box_avg(input hsum_t top, input hsum_t bot);
    logic [HR_W:0] r;
    logic [HG_W:0] g;
    logic [HB_W:0] b;
    rgb565_t       o;
    r   = (HR_W+1)'(top.r) + (HR_W+1)'(bot.r) + (HR_W+1)'(2);
    g   = (HG_W+1)'(top.g) + (HG_W+1)'(bot.g) + (HG_W+1)'(2);
    b   = (HB_W+1)'(top.b) + (HB_W+1)'(bot.b) + (HB_W+1)'(2);
    o.r = r[HR_W:2];
    o.g = g[HG_W:2];
    o.b = b[HB_W:2];
    return o;
  endfunction

endpackage

// File: rtl/video_half_scaler_if.sv
// Pixel stream bundle: frame sync, pixel valid and RGB565 data.
interface video_half_scaler_if;
  logic        vs;
  logic        de;
  logic [15:0] data;

  modport master (output vs, de, data);
  modport slave  (input  vs, de, data);
endinterface

// File: rtl/video_half_scaler_line_ram.sv
// Simple dual-port line buffer holding one even line of horizontal pair sums.
module half_line_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 19
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: storage and read register carry no reset; contents are don't-care
  // after reset, and a reset would prevent mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/video_half_scaler.sv
// 2:1 horizontal+vertical RGB565 downscaler with two-cycle output latency.
// HALF_SCALE_AVG_EN selects 2x2 rounded box average; otherwise top-left decimation.
module video_half_scaler
  import video_half_scaler_pkg::*;
#(
  parameter int IMG_COL = 1280,
  parameter int IMG_ROW = 720,
  parameter int ADDR_W  = 10
) (
  input  logic                        Img_pclk_i,
  input  logic                        sys_rst_n,
  video_half_scaler_if.slave          img_i,
  video_half_scaler_if.master         img_o
);

  // Odd sizes round down so a trailing unpaired pixel or line never emits.
  localparam int COL_LIM = (IMG_COL / 2) * 2;
  localparam int ROW_LIM = (IMG_ROW / 2) * 2;
  localparam int CW      = ADDR_W + 2;
  localparam int RW      = $clog2(IMG_ROW + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            de_prev_q, de_prev_d;
  logic [LAT-1:0]  vs_pipe_q, vs_pipe_d;
  logic            s1_valid_q, s1_valid_d;
  rgb565_t         s1_data_q, s1_data_d;
  logic            de_o_q, de_o_d;
  rgb565_t         data_o_q, data_o_d;

  logic            de_fall;
  logic            pix_ok;
  logic            pix_odd;
  rgb565_t         pix;

  assign pix     = rgb565_t'(img_i.data);
  assign de_fall = de_prev_q & ~img_i.de;
  assign pix_odd = col_q[0];
  assign pix_ok  = img_i.de & ~img_i.vs & (state_q != S_IDLE) &
                   (col_q < CW'(COL_LIM)) & (row_q < RW'(ROW_LIM));

`ifdef HALF_SCALE_AVG_EN
  rgb565_t           hold_q, hold_d;
  logic              ram_we;
  logic              ram_re;
  logic [HSUM_W-1:0] ram_rdata;
  hsum_t             h_cur;

  assign h_cur = pair_sum(hold_q, pix);

  half_line_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (HSUM_W)
  ) u_line_ram (
    .clk   (Img_pclk_i),
    .we    (ram_we),
    .waddr (col_q[ADDR_W:1]),
    .wdata (h_cur),
    .re    (ram_re),
    .raddr (col_q[ADDR_W:1]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge Img_pclk_i or negedge sys_rst_n) begin
    if (!sys_rst_n) hold_q <= '0;
    else            hold_q <= hold_d;
  end
`endif

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    de_prev_d  = img_i.de & ~img_i.vs;
    vs_pipe_d  = {vs_pipe_q[LAT-2:0], img_i.vs};
    s1_valid_d = 1'b0;
    s1_data_d  = s1_data_q;
    de_o_d     = s1_valid_q & ~img_i.vs;
    data_o_d   = de_o_d ? s1_data_q : data_o_q;
`ifdef HALF_SCALE_AVG_EN
    hold_d     = hold_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
`endif

    if (img_i.vs) begin
      state_d = S_IDLE;
      col_d   = '0;
      row_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_EVEN;
        S_EVEN:  if (de_fall) state_d = S_ODD;
        S_ODD:   if (de_fall) state_d = S_EVEN;
        default: state_d = S_IDLE;
      endcase
      if (de_fall) begin
        col_d = '0;
        if (row_q < RW'(ROW_LIM)) row_d = row_q + RW'(1);
      end else if (img_i.de && state_q != S_IDLE && col_q < CW'(COL_LIM)) begin
        col_d = col_q + CW'(1);
      end
    end

    if (pix_ok) begin
`ifdef HALF_SCALE_AVG_EN
      // The even column prefetches the upper pair sum for the odd column.
      if (!pix_odd) begin
        hold_d = pix;
        ram_re = 1'b1;
      end else if (state_q == S_EVEN) begin
        ram_we = 1'b1;
      end else begin
        s1_valid_d = 1'b1;
        s1_data_d  = box_avg(hsum_t'(ram_rdata), h_cur);
      end
`else
      if (!pix_odd && state_q == S_EVEN) begin
        s1_valid_d = 1'b1;
        s1_data_d  = pix;
      end
`endif
    end
  end

  always_ff @(posedge Img_pclk_i or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      de_prev_q  <= 1'b0;
      vs_pipe_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      de_o_q     <= 1'b0;
      data_o_q   <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      de_prev_q  <= de_prev_d;
      vs_pipe_q  <= vs_pipe_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      de_o_q     <= de_o_d;
      data_o_q   <= data_o_d;
    end
  end

  assign img_o.vs   = vs_pipe_q[LAT-1];
  assign img_o.de   = de_o_q;
  assign img_o.data = data_o_q;

endmodule

// File: tb/tb_video_half_scaler.sv
// Scoreboard bench for video_half_scaler on an 11x7 frame (odd sizes, so the
// last column and line are dropped); expected pixels are queued as driven.
module tb_video_half_scaler;

  localparam int COLS    = 11;
  localparam int ROWS    = 7;
  localparam int COL_LIM = 10;
  localparam int ROW_LIM = 6;

  localparam int PAT_FLAT  = 0;
  localparam int PAT_RAND  = 1;
  localparam int PAT_BLOCK = 2;
  localparam int PAT_RAMP  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  video_half_scaler_if img_in ();
  video_half_scaler_if img_out ();

  video_half_scaler #(
    .IMG_COL (COLS),
    .IMG_ROW (ROWS),
    .ADDR_W  (3)
  ) dut (
    .Img_pclk_i (clk),
    .sys_rst_n  (rst_n),
    .img_i      (img_in),
    .img_o      (img_out)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          out_cnt  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_data = '0;
  logic [15:0] exp_d;
  logic        vs_h1 = 1'b0;
  logic        vs_h2 = 1'b0;
  logic [15:0] ev_line [16];
  logic [15:0] cur_line [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] avg4(input logic [15:0] a, b, c, d);
    int r, g, bl;
    r  = (int'(a[15:11]) + int'(b[15:11]) + int'(c[15:11]) + int'(d[15:11]) + 2) / 4;
    g  = (int'(a[10:5])  + int'(b[10:5])  + int'(c[10:5])  + int'(d[10:5])  + 2) / 4;
    bl = (int'(a[4:0])   + int'(b[4:0])   + int'(c[4:0])   + int'(d[4:0])   + 2) / 4;
    return {5'(r), 6'(g), 5'(bl)};
  endfunction

  // Reference for vs_o: the input as sampled two edges earlier.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_h1 <= 1'b0;
      vs_h2 <= 1'b0;
    end else begin
      vs_h2 <= vs_h1;
      vs_h1 <= img_in.vs;
    end
  end

  always @(negedge clk) begin
    check("vs_o", img_out.vs, vs_h2);
    if (img_out.de) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        check("stray_de", img_out.de, 1'b0);
      end else begin
        exp_d = exp_q.pop_front();
        check("data_o", img_out.data, exp_d);
        last_data = exp_d;
      end
    end else begin
      check("data_hold", img_out.data, last_data);
    end
  end

  // cut_row/cut_col < 0 means no interruption; cut_rst picks reset over vs.
  task automatic run_frame(input int pat, input int rows, input int cols,
                           input int short_row, input int cut_row, input int cut_col,
                           input bit cut_rst, input int exp_total);
    int          exp_cnt;
    int          len;
    bit          pushed;
    logic [15:0] d;
    exp_cnt = 0;
    pushed  = 1'b0;
    out_cnt = 0;
    img_in.vs = 1'b0;
    img_in.de = 1'b0;
    repeat (3) tick();
    for (int r = 0; r < rows; r++) begin
      len = (r == short_row) ? 6 : cols;
      for (int c = 0; c < len; c++) begin
        if (r == cut_row && c == cut_col) begin
          if (cut_rst) begin
            rst_n = 1'b0;
            exp_q.delete();
            last_data = '0;
            #1;
            check("rst_mid_de", img_out.de, 1'b0);
            check("rst_mid_data", img_out.data, 16'h0);
            check("rst_mid_vs", img_out.vs, 1'b0);
            img_in.de = 1'b0;
            img_in.vs = 1'b1;
            repeat (3) tick();
            rst_n = 1'b1;
          end else begin
            if (pushed) begin
              void'(exp_q.pop_back());
              exp_cnt--;
            end
            img_in.de = 1'b0;
            img_in.vs = 1'b1;
          end
          repeat (6) tick();
          if (!cut_rst) check("abort_cnt", out_cnt, exp_cnt);
          check("abort_queue", exp_q.size(), 0);
          return;
        end
        case (pat)
          PAT_FLAT:  d = 16'hFFFF;
          PAT_RAND:  d = 16'($urandom);
          PAT_BLOCK: begin
            if ((((r / 2) + (c / 2)) % 2) == 0)
              d = {5'(1 + 2 * (r % 2) + (c % 2)), 11'h0};
            else
              d = {((r % 2 == 1) && (c % 2 == 1)) ? 5'd1 : 5'd0, 11'h0};
          end
          default:   d = 16'(c);
        endcase
        pushed = 1'b0;
        if (c < 16) cur_line[c] = d;
`ifdef HALF_SCALE_AVG_EN
        if (r % 2 == 0 && c < COL_LIM) ev_line[c] = d;
        if (r % 2 == 1 && c % 2 == 1 && c < COL_LIM && r < ROW_LIM) begin
          exp_q.push_back(avg4(ev_line[c-1], ev_line[c], cur_line[c-1], d));
          pushed = 1'b1;
        end
`else
        if (r % 2 == 0 && c % 2 == 0 && c < COL_LIM && r < ROW_LIM) begin
          exp_q.push_back(d);
          pushed = 1'b1;
        end
`endif
        if (pushed) exp_cnt++;
        img_in.de   = 1'b1;
        img_in.data = d;
        tick();
      end
      img_in.de = 1'b0;
      pushed    = 1'b0;
      repeat (3) tick();
    end
    img_in.vs = 1'b1;
    repeat (4) tick();
    check("frame_cnt", out_cnt, exp_cnt);
    if (exp_total >= 0) check("frame_total", out_cnt, exp_total);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    img_in.vs   = 1'b1;
    img_in.de   = 1'b0;
    img_in.data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_de", img_out.de, 1'b0);
    check("rst_data", img_out.data, 16'h0);
    check("rst_vs", img_out.vs, 1'b0);
    rst_n = 1'b1;
    repeat (3) tick();

    run_frame(PAT_FLAT,  ROWS,     COLS,     -1, -1, -1, 1'b0, 15);
    run_frame(PAT_RAND,  ROWS + 1, COLS + 2, -1, -1, -1, 1'b0, 15);
    run_frame(PAT_BLOCK, ROWS,     COLS,     -1, -1, -1, 1'b0, 15);
    run_frame(PAT_RAMP,  ROWS,     COLS + 1,  4, -1, -1, 1'b0, -1);
    run_frame(PAT_RAND,  ROWS,     COLS,      3, -1, -1, 1'b0, -1);
    run_frame(PAT_RAND,  ROWS,     COLS,     -1,  1,  4, 1'b0, -1);
    run_frame(PAT_FLAT,  ROWS,     COLS,     -1, -1, -1, 1'b0, 15);
    run_frame(PAT_RAND,  ROWS,     COLS,     -1,  2,  1, 1'b0, -1);
    run_frame(PAT_RAND,  ROWS,     COLS,     -1,  3,  5, 1'b1, -1);
    run_frame(PAT_RAND,  ROWS,     COLS,     -1, -1, -1, 1'b0, 15);
    run_frame(PAT_BLOCK, ROWS,     COLS + 3, -1, -1, -1, 1'b0, 15);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
